// File: rtl/sample_block_accumulator.sv
// Sums sign-extended samples over blocks of block_len (0 -> 1) with signed saturation; out_valid rises the cycle after the last accept.
// Backpressure: in_ready drops while a completed block waits in HOLD for out_ready, so at least one bubble per block.
module sample_block_accumulator #(
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 24,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [COUNT_WIDTH-1:0] block_len,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_sum,
  output logic                   out_sat,
  output logic [COUNT_WIDTH-1:0] out_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t                        state;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic [COUNT_WIDTH-1:0]        count;
  logic [COUNT_WIDTH-1:0]        len;
  logic                          sat;

  logic                          accept;
  logic signed [ACC_WIDTH:0]     data_ext;
  logic signed [ACC_WIDTH:0]     sum_ext;
  logic signed [ACC_WIDTH-1:0]   data_acc;
  logic signed [ACC_WIDTH-1:0]   sum_sat;
  logic                          sum_ovf;
  logic [COUNT_WIDTH-1:0]        len_eff;
  logic [COUNT_WIDTH-1:0]        count_nxt;

  assign in_ready  = (state != HOLD);
  assign accept    = in_valid & in_ready;
  assign data_ext  = (ACC_WIDTH+1)'($signed(in_data));
  assign data_acc  = data_ext[ACC_WIDTH-1:0];
  assign sum_ext   = (ACC_WIDTH+1)'(acc) + data_ext;
  assign len_eff   = (block_len == '0) ? COUNT_WIDTH'(1) : block_len;
  assign count_nxt = count + COUNT_WIDTH'(1);

  // One guard bit: overflow shows up as the top two bits disagreeing.
  always_comb begin
    sum_sat = sum_ext[ACC_WIDTH-1:0];
    sum_ovf = 1'b0;
    if (sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1]) begin
      sum_ovf = 1'b1;
      sum_sat = sum_ext[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      len       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            len   <= len_eff;
            acc   <= data_acc;
            count <= COUNT_WIDTH'(1);
            sat   <= 1'b0;
            if (len_eff == COUNT_WIDTH'(1)) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc   <= sum_sat;
            sat   <= sat | sum_ovf;
            count <= count_nxt;
            if (count_nxt == len) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_sum   = acc;
  assign out_sat   = sat;
  assign out_count = len;

endmodule

// File: tb/tb_sample_block_accumulator.sv
// Drives a 24-bit and a 16-bit accumulator with identical stimulus; a scoreboard of
// saturating block sums from a sample-list model is checked by an independent monitor.
module tb_sample_block_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic [7:0]  block_len = '0;
  logic        out_ready = 1'b1;

  logic        a_in_ready, a_out_valid, a_out_sat;
  logic [23:0] a_out_sum;
  logic [7:0]  a_out_count;
  logic        b_in_ready, b_out_valid, b_out_sat;
  logic [15:0] b_out_sum;
  logic [7:0]  b_out_count;

  sample_block_accumulator u_acc24 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .block_len(block_len), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_sum(a_out_sum), .out_sat(a_out_sat),
    .out_count(a_out_count)
  );

  sample_block_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(16), .COUNT_WIDTH(8)) u_acc16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .block_len(block_len), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_sum(b_out_sum), .out_sat(b_out_sat),
    .out_count(b_out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s24;
    bit t24;
    int s16;
    bit t16;
    int cnt;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   cur_q[$];
  int   cur_len = 1;
  exp_t exp_q[$];
  exp_t e_new;
  exp_t e_got;
  int   blocks_seen = 0;
  int   last_s24 = 0, last_s16 = 0, last_cnt = 0;
  bit   last_t24 = 0, last_t16 = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int sat_sum(input int q[$], input int w, output bit s);
    longint a, mx, mn;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -(longint'(1) << (w - 1));
    s = 1'b0;
    a = q[0];
    for (int i = 1; i < q.size(); i++) begin
      a += q[i];
      if (a > mx) begin a = mx; s = 1'b1; end
      else if (a < mn) begin a = mn; s = 1'b1; end
    end
    return int'(a);
  endfunction

  // Reference model: collects accepted samples into a block, then pushes its expected result.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q.delete();
      exp_q.delete();
    end else if (in_valid && a_in_ready) begin
      if (cur_q.size() == 0) cur_len = (block_len == 0) ? 1 : int'(block_len);
      cur_q.push_back(int'($signed(in_data)));
      if (cur_q.size() == cur_len) begin
        e_new.s24 = sat_sum(cur_q, 24, e_new.t24);
        e_new.s16 = sat_sum(cur_q, 16, e_new.t16);
        e_new.cnt = cur_len;
        exp_q.push_back(e_new);
        cur_q.delete();
      end
    end
  end

  // Monitor: pops on each output handshake.
  always @(posedge clk) begin
    if (rst_n && a_out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_block", 1, 0);
      end else begin
        e_got = exp_q.pop_front();
        chk("sum24", longint'($signed(a_out_sum)), e_got.s24);
        chk("sat24", a_out_sat, e_got.t24);
        chk("cnt24", a_out_count, e_got.cnt);
        chk("sum16", longint'($signed(b_out_sum)), e_got.s16);
        chk("sat16", b_out_sat, e_got.t16);
        chk("cnt16", b_out_count, e_got.cnt);
        last_s24 = int'($signed(a_out_sum));
        last_s16 = int'($signed(b_out_sum));
        last_t24 = a_out_sat;
        last_t16 = b_out_sat;
        last_cnt = int'(a_out_count);
        blocks_seen++;
      end
    end
  end

  // Per-cycle handshake timing and hold-stability checks.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid24", a_out_valid, exp_q.size() != 0);
      chk("out_valid16", b_out_valid, exp_q.size() != 0);
      chk("in_ready24", a_in_ready, exp_q.size() == 0);
      chk("in_ready16", b_in_ready, exp_q.size() == 0);
      if (exp_q.size() != 0) begin
        chk("hold_sum24", longint'($signed(a_out_sum)), exp_q[0].s24);
        chk("hold_sum16", longint'($signed(b_out_sum)), exp_q[0].s16);
      end
    end
  end

  task automatic send(input int d, input int bl);
    int w;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 16'(d);
    block_len = 8'(bl);
    w = 0;
    while (!a_in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_blocks(input int n);
    int w;
    w = 0;
    while (blocks_seen < n && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (blocks_seen < n) chk("block_timeout", blocks_seen, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int m;
    repeat (2) @(negedge clk);
    chk("rst_out_valid24", a_out_valid, 0);
    chk("rst_in_ready24", a_in_ready, 1);
    chk("rst_out_sum24", a_out_sum, 0);
    chk("rst_out_sat24", a_out_sat, 0);
    chk("rst_out_count24", a_out_count, 0);
    chk("rst_out_valid16", b_out_valid, 0);
    chk("rst_in_ready16", b_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    nb = blocks_seen;
    send(1, 4); send(-1, 4); send(5, 4); send(-2, 4);
    wait_blocks(nb + 1);
    chk("basic_sum", last_s24, 3);
    chk("basic_sat", last_t24, 0);
    chk("basic_count", last_cnt, 4);

    nb = blocks_seen;
    send('h7000, 2); send('h7000, 2);
    wait_blocks(nb + 1);
    chk("pos_sat_sum16", last_s16, 32767);
    chk("pos_sat_flag16", last_t16, 1);
    chk("pos_sat_sum24", last_s24, 'hE000);
    chk("pos_sat_flag24", last_t24, 0);

    // After clamping at -32768 the block recovers from the clamped value.
    nb = blocks_seen;
    send('h8000, 3); send('hFFFF, 3); send('h0010, 3);
    wait_blocks(nb + 1);
    chk("neg_sat_sum16", last_s16, -32752);
    chk("neg_sat_flag16", last_t16, 1);
    chk("neg_sum24", last_s24, -32753);

    nb = blocks_seen;
    out_ready = 1'b0;
    send(3, 2); send(4, 2);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'd99;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", a_in_ready, 0);
      chk("bp_out_valid", a_out_valid, 1);
      chk("bp_sum", a_out_sum, 7);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", a_out_valid, 0);
    chk("bp_release_ready", a_in_ready, 1);
    chk("bp_block_seen", blocks_seen, nb + 1);

    nb = blocks_seen;
    send(9, 0);
    wait_blocks(nb + 1);
    chk("len0_count", last_cnt, 1);
    chk("len0_sum", last_s24, 9);

    nb = blocks_seen;
    send(1, 4); send(2, 2); send(3, 2);
    @(negedge clk);
    chk("len_change_early", blocks_seen, nb);
    send(4, 2);
    wait_blocks(nb + 1);
    chk("len_change_count", last_cnt, 4);
    chk("len_change_sum", last_s24, 10);

    nb = blocks_seen;
    send(100, 4); send(200, 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", a_out_valid, 0);
    chk("mid_rst_ready", a_in_ready, 1);
    chk("mid_rst_count", a_out_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(1, 4); send(2, 4); send(3, 4); send(4, 4);
    wait_blocks(nb + 1);
    chk("post_rst_sum", last_s24, 10);
    chk("post_rst_count", last_cnt, 4);

    nb = blocks_seen;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      in_valid = ($urandom % 4) != 0;
      m = $urandom % 4;
      if (m == 0)      in_data = 16'h6000 + 16'($urandom % 'h2000);
      else if (m == 1) in_data = 16'h8000 + 16'($urandom % 'h2000);
      else             in_data = 16'($urandom);
      if ($urandom % 8 == 0) block_len = 8'($urandom % 6);
      out_ready = ($urandom % 3) != 0;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
    chk("random_activity", blocks_seen > nb + 50, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
